// File: rtl/op_dispatch_pkg.sv
// Shared types and constants for the op_dispatch command sequencer.
package op_dispatch_pkg;

  localparam int unsigned OP_W      = 4;
  localparam int unsigned FLAG_W    = 3;
  localparam int unsigned NUM_LANES = 12;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_COMP = 4'd1,
    OP_DEC  = 4'd2,
    OP_DIV  = 4'd3,
    OP_INC  = 4'd4,
    OP_MOD  = 4'd5,
    OP_MUL  = 4'd6,
    OP_MUX  = 4'd7,
    OP_REG  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_SUB  = 4'd11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/op_result_mux.sv
// Selects the datapath lane matching the opcode; COMP and illegal opcodes yield 0.
module op_result_mux
  import op_dispatch_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 2
) (
  input  logic [NUM_LANES*DATAWIDTH-1:0] dp_res,
  input  logic [OP_W-1:0]                op,
  output logic [DATAWIDTH-1:0]           res_c
);

  // Lane 1 (comparator) carries no data result.
  logic unused_lane1_c;
  assign unused_lane1_c = ^dp_res[DATAWIDTH +: DATAWIDTH];

  // One-hot lane pick; unmatched opcodes leave the result at zero.
  always_comb begin
    res_c = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if ((k != 1) && (op == OP_W'(k))) begin
        res_c = dp_res[k*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

endmodule

// File: rtl/op_dispatch.sv
// Command sequencer: latches operands to the datapath, captures the selected
// result one (or two, for REG) cycles later and holds it until accepted.
// Optional build macro OP_DISPATCH_ERR_EN flags divide-by-zero and illegal
// opcodes with res_err and an all-ones result.
module op_dispatch
  import op_dispatch_pkg::*;
#(
  parameter  int unsigned DATAWIDTH = 2,
  localparam int unsigned AMTWIDTH  = $clog2(DATAWIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [OP_W-1:0]               cmd_op,
  input  logic [DATAWIDTH-1:0]          cmd_a,
  input  logic [DATAWIDTH-1:0]          cmd_b,
  input  logic [AMTWIDTH-1:0]           cmd_amt,
  output logic [DATAWIDTH-1:0]          dp_a,
  output logic [DATAWIDTH-1:0]          dp_b,
  output logic [AMTWIDTH-1:0]           dp_amt,
  output logic                          dp_sel,
  input  logic [NUM_LANES*DATAWIDTH-1:0] dp_res,
  input  logic                          dp_gt,
  input  logic                          dp_lt,
  input  logic                          dp_eq,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATAWIDTH-1:0]          res_data,
  output logic [FLAG_W-1:0]             res_flags,
  output logic [OP_W-1:0]               res_op,
  output logic                          res_err
);

  state_e                state_q, state_d;
  logic [OP_W-1:0]       op_q, op_d;
  logic [DATAWIDTH-1:0]  dp_a_q, dp_a_d;
  logic [DATAWIDTH-1:0]  dp_b_q, dp_b_d;
  logic [AMTWIDTH-1:0]   dp_amt_q, dp_amt_d;
  logic                  dp_sel_q, dp_sel_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATAWIDTH-1:0]  res_data_q, res_data_d;
  logic [FLAG_W-1:0]     res_flags_q, res_flags_d;
  logic [OP_W-1:0]       res_op_q, res_op_d;
  logic                  res_err_q, res_err_d;

  logic [DATAWIDTH-1:0]  lane_res_c;
  logic                  err_c;
  logic                  capture_c;

  op_result_mux #(.DATAWIDTH(DATAWIDTH)) u_mux (
    .dp_res (dp_res),
    .op     (op_q),
    .res_c  (lane_res_c)
  );

  // Error condition for the in-flight opcode, evaluated on held operands.
`ifdef OP_DISPATCH_ERR_EN
  assign err_c = (op_q >= OP_W'(NUM_LANES)) ||
                 (((op_q == OP_DIV) || (op_q == OP_MOD)) && (dp_b_q == '0));
`else
  assign err_c = 1'b0;
`endif

  // Next-state, operand latch and result capture.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    dp_amt_d    = dp_amt_q;
    dp_sel_d    = dp_sel_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;
    capture_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d     = cmd_op;
          dp_a_d   = cmd_a;
          dp_b_d   = cmd_b;
          dp_amt_d = cmd_amt;
          dp_sel_d = cmd_amt[0];
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_q == OP_REG) begin
          state_d = ST_SETTLE;
        end else begin
          capture_c = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_SETTLE: begin
        capture_c = 1'b1;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture_c) begin
      res_op_d    = op_q;
      res_err_d   = err_c;
      res_data_d  = err_c ? {DATAWIDTH{1'b1}} : lane_res_c;
      res_flags_d = (op_q == OP_COMP) ? {dp_gt, dp_lt, dp_eq} : '0;
    end

    cmd_ready_d = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_amt_q    <= '0;
      dp_sel_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      dp_amt_q    <= dp_amt_d;
      dp_sel_q    <= dp_sel_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign dp_amt    = dp_amt_q;
  assign dp_sel    = dp_sel_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign res_op    = res_op_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_op_dispatch.sv
// Directed bench for op_dispatch at DATAWIDTH=8 with a behavioural datapath.
module tb_op_dispatch;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned NV = 17;
`ifdef OP_DISPATCH_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic [AW-1:0] cmd_amt = '0;
  logic [DW-1:0] dp_a, dp_b;
  logic [AW-1:0] dp_amt;
  logic          dp_sel;
  logic [12*DW-1:0] dp_res;
  logic          dp_gt, dp_lt, dp_eq;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic [2:0]    res_flags;
  logic [3:0]    res_op;
  logic          res_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  op_dispatch #(.DATAWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_amt(cmd_amt),
    .dp_a(dp_a), .dp_b(dp_b), .dp_amt(dp_amt), .dp_sel(dp_sel),
    .dp_res(dp_res), .dp_gt(dp_gt), .dp_lt(dp_lt), .dp_eq(dp_eq),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .res_op(res_op), .res_err(res_err)
  );

  // Behavioural datapath units; divide/mod by zero give marker values.
  logic [DW-1:0] lane [12];
  always_comb begin
    lane[0]  = dp_a + dp_b;
    lane[1]  = 8'hC3;
    lane[2]  = dp_a - 8'd1;
    lane[3]  = (dp_b == 0) ? 8'hEE : dp_a / dp_b;
    lane[4]  = dp_a + 8'd1;
    lane[5]  = (dp_b == 0) ? 8'hDD : dp_a % dp_b;
    lane[6]  = dp_a * dp_b;
    lane[7]  = dp_sel ? dp_b : dp_a;
    lane[8]  = dp_a;
    lane[9]  = dp_a << dp_amt;
    lane[10] = dp_a >> dp_amt;
    lane[11] = dp_a - dp_b;
    for (int k = 0; k < 12; k++) dp_res[k*DW +: DW] = lane[k];
    dp_gt = (dp_a > dp_b);
    dp_lt = (dp_a < dp_b);
    dp_eq = (dp_a == dp_b);
  end

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] amt;
    logic [DW-1:0] exp_data;
    logic [2:0]    exp_flags;
    logic          exp_err;
    int            lat;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue one command, time the result, check it, then drain it.
  task automatic run_vec(input int idx, input vec_t v);
    int  cyc;
    bit  seen;
    @(negedge clk);
    check($sformatf("v%0d_ready_idle", idx), 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_amt = v.amt;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_amt = '0; cmd_op = '0;
    cyc = 0; seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (res_valid) seen = 1'b1;
    end
    check($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.lat));
    check($sformatf("v%0d_data", idx), 32'(res_data), 32'(v.exp_data));
    check($sformatf("v%0d_flags", idx), 32'(res_flags), 32'(v.exp_flags));
    check($sformatf("v%0d_op", idx), 32'(res_op), 32'(v.op));
    check($sformatf("v%0d_err", idx), 32'(res_err), 32'(v.exp_err));
    check($sformatf("v%0d_ready_busy", idx), 32'(cmd_ready), 32'd0);
    check($sformatf("v%0d_dp_a_held", idx), 32'(dp_a), 32'(v.a));
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_valid_drop", idx), 32'(res_valid), 32'd0);
    check($sformatf("v%0d_ready_back", idx), 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{4'd0,  8'd3,   8'd4,  3'd0, 8'd7,   3'b000, 1'b0, 2};
    vecs[1]  = '{4'd8,  8'h5A,  8'd0,  3'd0, 8'h5A,  3'b000, 1'b0, 3};
    vecs[2]  = '{4'd1,  8'd2,   8'd9,  3'd0, 8'd0,   3'b010, 1'b0, 2};
    vecs[3]  = '{4'd1,  8'd9,   8'd2,  3'd0, 8'd0,   3'b100, 1'b0, 2};
    vecs[4]  = '{4'd1,  8'd5,   8'd5,  3'd0, 8'd0,   3'b001, 1'b0, 2};
    vecs[5]  = '{4'd11, 8'd9,   8'd2,  3'd0, 8'd7,   3'b000, 1'b0, 2};
    vecs[6]  = '{4'd2,  8'd0,   8'd0,  3'd0, 8'hFF,  3'b000, 1'b0, 2};
    vecs[7]  = '{4'd4,  8'hFF,  8'd0,  3'd0, 8'h00,  3'b000, 1'b0, 2};
    vecs[8]  = '{4'd6,  8'd5,   8'd6,  3'd0, 8'h1E,  3'b000, 1'b0, 2};
    vecs[9]  = '{4'd3,  8'd20,  8'd6,  3'd0, 8'd3,   3'b000, 1'b0, 2};
    vecs[10] = '{4'd5,  8'd20,  8'd6,  3'd0, 8'd2,   3'b000, 1'b0, 2};
    vecs[11] = '{4'd7,  8'hAA,  8'h55, 3'd1, 8'h55,  3'b000, 1'b0, 2};
    vecs[12] = '{4'd9,  8'h81,  8'd0,  3'd3, 8'h08,  3'b000, 1'b0, 2};
    vecs[13] = '{4'd10, 8'h81,  8'd0,  3'd7, 8'h01,  3'b000, 1'b0, 2};
    vecs[14] = '{4'd3,  8'd7,   8'd0,  3'd0, ERR ? 8'hFF : 8'hEE, 3'b000, ERR, 2};
    vecs[15] = '{4'd5,  8'd7,   8'd0,  3'd0, ERR ? 8'hFF : 8'hDD, 3'b000, ERR, 2};
    vecs[16] = '{4'd13, 8'd7,   8'd3,  3'd2, ERR ? 8'hFF : 8'h00, 3'b000, ERR, 2};

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_dp", 32'({dp_a, dp_b, dp_amt, dp_sel}), 32'd0);
    check("rst_res_misc", 32'({res_flags, res_op, res_err}), 32'd0);
    rst = 1'b1;

    // res_ready and idle cmd_valid low have no effect in IDLE.
    @(negedge clk);
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    res_ready = 1'b0;
    check("idle_ready_noeffect_valid", 32'(res_valid), 32'd0);
    check("idle_ready_noeffect_cmd", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < int'(NV); i++) run_vec(i, vecs[i]);

    // COMP held in HOLD for 5 cycles with res_ready low.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 8'd2; cmd_b = 8'd9;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_a = 8'd77; cmd_b = 8'd1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_valid", i), 32'(res_valid), 32'd1);
      check($sformatf("hold%0d_flags", i), 32'(res_flags), 32'b010);
      check($sformatf("hold%0d_data", i), 32'(res_data), 32'd0);
      check($sformatf("hold%0d_cmd_ready", i), 32'(cmd_ready), 32'd0);
      check($sformatf("hold%0d_dp", i), 32'({dp_a, dp_b}), 32'h0209);
      cmd_valid = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("hold_release_ready", 32'(cmd_ready), 32'd1);
    check("hold_no_overlap_dp", 32'(dp_a), 32'd2);

    // Reset during SETTLE abandons the REG op.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd8; cmd_a = 8'h33;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("settle_rst_valid", 32'(res_valid), 32'd0);
    check("settle_rst_ready", 32'(cmd_ready), 32'd1);
    check("settle_rst_dp", 32'(dp_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("settle_after_ready", 32'(cmd_ready), 32'd1);
    begin
      bit rose = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (res_valid) rose = 1'b1;
      end
      check("settle_never_valid", 32'(rose), 32'd0);
    end
    run_vec(99, vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
